// File: rtl/psum_drain.sv
// psum_drain: de-skews the array's bottom-row partial sums and queues aligned rows in a FWFT FIFO
module psum_drain #(
   parameter int DATA_WIDTH = 16,
   parameter int COLS = 4,
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [COLS*DATA_WIDTH-1:0] psum_in,
   input  logic                       start,
   input  logic [CNT_W-1:0]           num_rows,
   output logic [COLS*DATA_WIDTH-1:0] out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   typedef enum logic {IDLE, CAPTURE} state_t;
   state_t state, state_nxt;
   logic [COLS*DATA_WIDTH-1:0] aligned;
   logic [COLS*DATA_WIDTH-1:0] mem [DEPTH];
   logic [COLS-2:0] vsr;
   logic [CNT_W-1:0] in_rem, push_rem;
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic start_ok, v0, push, last, pop, wr, full;

   for (genvar c = 0; c < COLS; c++) begin : g_col
      if (c == COLS-1) begin : g_thru
         assign aligned[c*DATA_WIDTH +: DATA_WIDTH] = psum_in[c*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr [COLS-1-c];
         always_ff @(posedge clk or negedge reset)
            if (!reset) begin
               for (int k = 0; k < COLS-1-c; k++) sr[k] <= '0;
            end else begin
               sr[0] <= psum_in[c*DATA_WIDTH +: DATA_WIDTH];
               for (int k = 1; k < COLS-1-c; k++) sr[k] <= sr[k-1];
            end
         assign aligned[c*DATA_WIDTH +: DATA_WIDTH] = sr[COLS-2-c];
      end
   end

   // column 0 carries rows in cycles 0..num_rows-1; delaying that by COLS-1 gives the push window
   assign start_ok  = start && state == IDLE && num_rows != '0;
   assign v0        = start_ok || in_rem != '0;
   assign push      = vsr[COLS-2] && state == CAPTURE;
   assign last      = push && push_rem == CNT_W'(1);
   assign full      = cnt == FULL_CNT;
   assign out_valid = cnt != '0;
   assign pop       = out_valid && out_ready;
   assign wr        = push && (!full || pop);
   assign out_data  = mem[rp];
   assign busy      = state == CAPTURE;

   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (start_ok ? CAPTURE : IDLE) : (last ? IDLE : CAPTURE);
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         vsr      <= '0;
         in_rem   <= '0;
         push_rem <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         wp       <= '0;
         rp       <= '0;
         cnt      <= '0;
      end else begin
         vsr[0] <= v0;
         for (int k = 1; k < COLS-1; k++) vsr[k] <= vsr[k-1];
         in_rem   <= start_ok ? num_rows - CNT_W'(1) : (in_rem != '0 ? in_rem - CNT_W'(1) : in_rem);
         push_rem <= start_ok ? num_rows : (push ? push_rem - CNT_W'(1) : push_rem);
         done     <= last;
         overflow <= start_ok ? 1'b0 : (overflow | (push & full & ~pop));
         wp       <= wr ? wp + 1'b1 : wp;
         rp       <= pop ? rp + 1'b1 : rp;
         cnt      <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (wr) begin
         mem[wp] <= aligned;
      end
endmodule
